// File: rtl/pe_nic.sv
// Network interface between one processing element and its mesh router port:
// a single-entry receive buffer, a single-entry send buffer and a 2-bit register map.
module pe_nic #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            addr,
  input  logic [DATA_WIDTH-1:0] d_in,
  output logic [DATA_WIDTH-1:0] d_out,
  input  logic                  nicEn,
  input  logic                  nicWrEn,
  output logic                  net_so,
  input  logic                  net_ro,
  output logic [DATA_WIDTH-1:0] net_do,
  input  logic                  net_polarity,
  input  logic                  net_si,
  output logic                  net_ri,
  input  logic [DATA_WIDTH-1:0] net_di
);

  localparam logic [1:0] AddrInBuf   = 2'd0;
  localparam logic [1:0] AddrInStat  = 2'd1;
  localparam logic [1:0] AddrOutBuf  = 2'd2;
  localparam logic [1:0] AddrOutStat = 2'd3;

  logic [DATA_WIDTH-1:0] inBuf_q, inBuf_d;
  logic [DATA_WIDTH-1:0] outBuf_q, outBuf_d;
  logic [DATA_WIDTH-1:0] dOut_q, dOut_d;
  logic                  inFull_q, inFull_d;
  logic                  outFull_q, outFull_d;

  logic procRead;
  logic procWrite;
  logic acceptPkt;

  assign procRead  = nicEn && !nicWrEn;
  assign procWrite = nicEn && nicWrEn;

  // Gating with reset keeps both handshakes quiet on the reset edge itself.
  assign net_ri    = !inFull_q && !reset;
  assign net_so    = outFull_q && net_ro && (outBuf_q[DATA_WIDTH-1] == net_polarity) && !reset;
  assign net_do    = outFull_q ? outBuf_q : '0;
  assign d_out     = dOut_q;
  assign acceptPkt = net_si && net_ri;

  always_comb begin
    inBuf_d   = inBuf_q;
    inFull_d  = inFull_q;
    outBuf_d  = outBuf_q;
    outFull_d = outFull_q;
    dOut_d    = dOut_q;

    if (acceptPkt) begin
      inBuf_d  = net_di;
      inFull_d = 1'b1;
    end

    if (net_so) begin
      outFull_d = 1'b0;
    end

    // A write to a full send buffer is dropped even if the buffer drains this edge.
    if (procWrite && (addr == AddrOutBuf) && !outFull_q) begin
      outBuf_d  = d_in;
      outFull_d = 1'b1;
    end

    if (procRead) begin
      case (addr)
        AddrInBuf: begin
          dOut_d = inBuf_q;
          if (inFull_q) begin
            inFull_d = 1'b0;
          end
        end
        AddrInStat:  dOut_d = {{(DATA_WIDTH-1){1'b0}}, inFull_q};
        AddrOutBuf:  dOut_d = outBuf_q;
        AddrOutStat: dOut_d = {{(DATA_WIDTH-1){1'b0}}, outFull_q};
        default:     dOut_d = dOut_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      inBuf_q   <= '0;
      inFull_q  <= 1'b0;
      outBuf_q  <= '0;
      outFull_q <= 1'b0;
      dOut_q    <= '0;
    end else begin
      inBuf_q   <= inBuf_d;
      inFull_q  <= inFull_d;
      outBuf_q  <= outBuf_d;
      outFull_q <= outFull_d;
      dOut_q    <= dOut_d;
    end
  end

endmodule

// File: tb/tb_pe_nic.sv
// Directed self-checking bench for pe_nic: inputs change 1ns after each rising
// edge and outputs are sampled there, well away from the next active edge.
module tb_pe_nic;

  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    addr;
  logic [DW-1:0] d_in;
  logic [DW-1:0] d_out;
  logic          nicEn;
  logic          nicWrEn;
  logic          net_so;
  logic          net_ro;
  logic [DW-1:0] net_do;
  logic          net_polarity;
  logic          net_si;
  logic          net_ri;
  logic [DW-1:0] net_di;

  int total = 0;
  int bad   = 0;

  pe_nic #(.DATA_WIDTH(DW)) dut (
    .clk          (clk),
    .reset        (reset),
    .addr         (addr),
    .d_in         (d_in),
    .d_out        (d_out),
    .nicEn        (nicEn),
    .nicWrEn      (nicWrEn),
    .net_so       (net_so),
    .net_ro       (net_ro),
    .net_do       (net_do),
    .net_polarity (net_polarity),
    .net_si       (net_si),
    .net_ri       (net_ri),
    .net_di       (net_di)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                             input logic [DW-1:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  // One processor access lasting a single edge; enable drops afterwards.
  task automatic applyStimulus(input logic wr, input logic [1:0] a, input logic [DW-1:0] data);
    nicEn   = 1'b1;
    nicWrEn = wr;
    addr    = a;
    d_in    = data;
    tick();
    nicEn   = 1'b0;
    nicWrEn = 1'b0;
  endtask

  // Router pushes one packet into the NIC on the next edge.
  task automatic injectPacket(input logic [DW-1:0] pkt);
    net_si = 1'b1;
    net_di = pkt;
    tick();
    net_si = 1'b0;
    net_di = '0;
  endtask

  initial begin
    #20000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1; addr = 2'd0; d_in = '0; nicEn = 1'b0; nicWrEn = 1'b0;
    net_ro = 1'b0; net_polarity = 1'b0; net_si = 1'b0; net_di = '0;
    tick();
    tick();
    checkOutput("reset_d_out",  d_out,  64'h0);
    checkOutput("reset_net_so", {63'h0, net_so}, 64'h0);
    checkOutput("reset_net_ri", {63'h0, net_ri}, 64'h0);
    checkOutput("reset_net_do", net_do, 64'h0);

    reset = 1'b0;
    tick();
    checkOutput("idle_net_ri", {63'h0, net_ri}, 64'h1);
    checkOutput("idle_net_so", {63'h0, net_so}, 64'h0);
    applyStimulus(1'b0, 2'd1, '0);
    checkOutput("idle_in_stat", d_out, 64'h0);
    applyStimulus(1'b0, 2'd3, '0);
    checkOutput("idle_out_stat", d_out, 64'h0);

    // Receive path
    injectPacket(64'h8000_0000_0000_00AB);
    checkOutput("rx_net_ri_full", {63'h0, net_ri}, 64'h0);
    applyStimulus(1'b0, 2'd1, '0);
    checkOutput("rx_in_stat", d_out, 64'h1);
    applyStimulus(1'b0, 2'd0, '0);
    checkOutput("rx_data", d_out, 64'h8000_0000_0000_00AB);
    checkOutput("rx_net_ri_reopen", {63'h0, net_ri}, 64'h1);
    applyStimulus(1'b0, 2'd1, '0);
    checkOutput("rx_in_stat_empty", d_out, 64'h0);
    applyStimulus(1'b0, 2'd0, '0);
    checkOutput("rx_stale_read", d_out, 64'h8000_0000_0000_00AB);
    checkOutput("rx_stale_net_ri", {63'h0, net_ri}, 64'h1);

    // Router strobing while the buffer is full must not overwrite it
    injectPacket(64'h0000_0000_0000_0C01);
    injectPacket(64'h0000_0000_0000_0BAD);
    applyStimulus(1'b0, 2'd0, '0);
    checkOutput("rx_violation_kept", d_out, 64'h0000_0000_0000_0C01);

    // Send with matching polarity
    net_ro = 1'b1; net_polarity = 1'b0;
    applyStimulus(1'b1, 2'd2, 64'h0000_0000_0000_1234);
    checkOutput("tx_net_so", {63'h0, net_so}, 64'h1);
    checkOutput("tx_net_do", net_do, 64'h0000_0000_0000_1234);
    tick();
    checkOutput("tx_net_so_once", {63'h0, net_so}, 64'h0);
    checkOutput("tx_net_do_clear", net_do, 64'h0);
    applyStimulus(1'b0, 2'd3, '0);
    checkOutput("tx_out_stat", d_out, 64'h0);

    // Polarity hold
    applyStimulus(1'b1, 2'd2, 64'h8000_0000_0000_0001);
    for (int i = 0; i < 5; i++) begin
      checkOutput("pol_hold_so", {63'h0, net_so}, 64'h0);
      checkOutput("pol_hold_do", net_do, 64'h8000_0000_0000_0001);
      tick();
    end
    applyStimulus(1'b0, 2'd3, '0);
    checkOutput("pol_hold_stat", d_out, 64'h1);
    net_polarity = 1'b1;
    #1;
    checkOutput("pol_release_so", {63'h0, net_so}, 64'h1);
    tick();
    checkOutput("pol_release_once", {63'h0, net_so}, 64'h0);
    applyStimulus(1'b0, 2'd3, '0);
    checkOutput("pol_release_stat", d_out, 64'h0);

    // Overflow drops, including a write on the draining edge
    net_ro = 1'b0; net_polarity = 1'b0;
    applyStimulus(1'b1, 2'd2, 64'h0000_0000_0000_00AA);
    applyStimulus(1'b1, 2'd2, 64'h5555_5555_5555_5555);
    applyStimulus(1'b0, 2'd2, '0);
    checkOutput("ovf_keep_buf", d_out, 64'h0000_0000_0000_00AA);
    net_ro  = 1'b1;
    nicEn   = 1'b1; nicWrEn = 1'b1; addr = 2'd2; d_in = 64'h5555_5555_5555_5555;
    #1;
    checkOutput("ovf_drain_so", {63'h0, net_so}, 64'h1);
    tick();
    nicEn = 1'b0; nicWrEn = 1'b0;
    checkOutput("ovf_drain_so_off", {63'h0, net_so}, 64'h0);
    applyStimulus(1'b0, 2'd3, '0);
    checkOutput("ovf_drain_stat", d_out, 64'h0);
    applyStimulus(1'b0, 2'd2, '0);
    checkOutput("ovf_drain_buf", d_out, 64'h0000_0000_0000_00AA);

    // Reset with both buffers full
    net_ro = 1'b0;
    injectPacket(64'h1111_2222_3333_4444);
    applyStimulus(1'b1, 2'd2, 64'h8000_0000_0000_0077);
    applyStimulus(1'b0, 2'd2, '0);
    checkOutput("mid_pre_d_out", d_out, 64'h8000_0000_0000_0077);
    net_ro = 1'b1; net_polarity = 1'b1; reset = 1'b1;
    #1;
    checkOutput("mid_rst_so", {63'h0, net_so}, 64'h0);
    checkOutput("mid_rst_ri", {63'h0, net_ri}, 64'h0);
    tick();
    reset = 1'b0;
    #1;
    checkOutput("mid_after_d_out", d_out, 64'h0);
    checkOutput("mid_after_so", {63'h0, net_so}, 64'h0);
    checkOutput("mid_after_do", net_do, 64'h0);
    checkOutput("mid_after_ri", {63'h0, net_ri}, 64'h1);
    applyStimulus(1'b0, 2'd1, '0);
    checkOutput("mid_in_stat", d_out, 64'h0);
    applyStimulus(1'b0, 2'd3, '0);
    checkOutput("mid_out_stat", d_out, 64'h0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("mid_no_send", {63'h0, net_so}, 64'h0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
